// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by the receive path and the transmit path.
//   rx_state_t         : receiver FSM state encoding
//   DEFAULT_OVERSAMPLE : tick_i pulses per bit period
//   DEFAULT_DATA_BITS  : data bits per frame
//   MAX_DATA_BITS      : widest data word the parity helper accepts
//   calc_parity()      : parity bit a transmitter sends for a data word
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int DEFAULT_OVERSAMPLE = 16;
    localparam int DEFAULT_DATA_BITS  = 8;
    localparam int MAX_DATA_BITS      = 9;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    // Narrower words are zero-extended by the caller.
    // Unused upper bits are zero, so they do not change the XOR.
    // The receiver flags an error when this result differs from the received bit.
    function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                         input logic                     odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// -----------------------------------------------------------------------------
// uart_sync2
// Generic two-flop synchroniser for a single asynchronous input.
//   clk_i : destination clock
//   rst_i : synchronous active-high reset; both flops load RESET_VAL
//   d     : asynchronous input
//   q     : synchronised output, two clk_i cycles of latency
// -----------------------------------------------------------------------------
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d,
    output logic q
);

    logic meta;

    // The reset value matches the idle level of the line.
    // This keeps reset release from looking like an edge downstream.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_parity.sv
// -----------------------------------------------------------------------------
// uart_rx_parity
// UART receiver driven by an external oversampling tick.
// Data is received LSB first.
// Parity (even or odd) is optional and checked when enabled.
// A stop-bit check reports framing errors.
//   clk_i        : system clock
//   rst_i        : synchronous active-high reset
//   tick_i       : oversampling strobe, OVERSAMPLE pulses per bit
//   rx_i         : asynchronous serial line, idle high
//   parity_en_i  : a parity bit follows the data
//   parity_odd_i : 1 = odd parity, 0 = even parity
//   data_o       : last received data word
//   valid_o      : one-cycle strobe; data_o and the error flags were updated
//   parity_err_o : parity mismatch for the frame flagged by valid_o
//   frame_err_o  : stop bit sampled low for the frame flagged by valid_o
//   busy_o       : receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx_parity
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEFAULT_DATA_BITS,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 tick_i,
    input  logic                 rx_i,
    input  logic                 parity_en_i,
    input  logic                 parity_odd_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    output logic                 parity_err_o,
    output logic                 frame_err_o,
    output logic                 busy_o
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_t            state_q, state_d;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_en_q, par_en_d;
    logic                 par_odd_q, par_odd_d;
    logic                 perr_q, perr_d;
    logic                 frame_done;

    uart_sync2 #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d     (rx_i),
        .q     (rx_s)
    );

    // State and datapath registers. The parity config is latched once per
    // frame, so changes to the input pins mid-frame have no effect.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_en_q   <= par_en_d;
            par_odd_q  <= par_odd_d;
            perr_q     <= perr_d;
        end
    end

    // Next-state logic. Counters only move on tick_i.
    // The wrap from TICK_LAST back to zero is written out explicitly
    // rather than relying on counter overflow.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        perr_d     = perr_q;
        frame_done = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (tick_i && !rx_s) begin
                    state_d    = START;
                    tick_cnt_d = '0;
                    par_en_d   = parity_en_i;
                    par_odd_d  = parity_odd_i;
                    perr_d     = 1'b0;
                end
            end

            START: begin
                if (tick_i) begin
                    if (tick_cnt_q == TICK_MID) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        // A start bit that is high again at mid-bit was a glitch.
                        state_d    = rx_s ? IDLE : DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end

            DATA: begin
                if (tick_i) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
                        tick_cnt_d = '0;
                        bit_cnt_d  = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = par_en_q ? PARITY : STOP;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end

            PARITY: begin
                if (tick_i) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        perr_d     = calc_parity(MAX_DATA_BITS'(shift_q), par_odd_q) ^ rx_s;
                        tick_cnt_d = '0;
                        state_d    = STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end

            STOP: begin
                if (tick_i) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        frame_done = 1'b1;
                        tick_cnt_d = '0;
                        // A low stop bit means break or a stuck line.
                        // Wait for the line to return high before arming again.
                        state_d    = rx_s ? IDLE : WAIT_IDLE;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end

            WAIT_IDLE: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output register. It updates on the edge that samples the stop bit,
    // so valid_o appears one cycle after the stop-sampling tick.
    // data_o and the flags hold their values until the next frame.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o      <= 1'b0;
            data_o       <= '0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
        end else begin
            valid_o <= frame_done;
            if (frame_done) begin
                data_o       <= shift_q;
                parity_err_o <= perr_q;
                frame_err_o  <= ~rx_s;
            end
        end
    end

    assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_parity.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_parity
// Testbench for uart_rx_parity.
// Serial frames are driven bit by bit on rx_i, aligned to the tick stream.
// Every valid_o strobe is collected by a monitor.
// Collected frames are compared with expected values from a table,
// from hand-written corner sequences, and from a frame-level model.
// -----------------------------------------------------------------------------
module tb_uart_rx_parity;

    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;
    localparam int TICK_DIV   = 4;

    logic                 clk_i        = 1'b0;
    logic                 rst_i        = 1'b1;
    logic                 tick_i       = 1'b0;
    logic                 rx_i         = 1'b1;
    logic                 parity_en_i  = 1'b0;
    logic                 parity_odd_i = 1'b0;
    logic [DATA_BITS-1:0] data_o;
    logic                 valid_o;
    logic                 parity_err_o;
    logic                 frame_err_o;
    logic                 busy_o;

    int          n_compared   = 0;
    int          n_mismatched = 0;
    int unsigned div_cnt      = 0;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } obs_t;

    typedef struct {
        logic [7:0] data;
        bit         par_en;
        bit         par_odd;
        bit         pbit;
        bit         stop;
        logic [7:0] exp_data;
        bit         exp_perr;
        bit         exp_ferr;
    } vec_t;

    obs_t obs_q[$];
    vec_t vecs[12];

    uart_rx_parity #(
        .DATA_BITS  (DATA_BITS),
        .OVERSAMPLE (OVERSAMPLE)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .tick_i       (tick_i),
        .rx_i         (rx_i),
        .parity_en_i  (parity_en_i),
        .parity_odd_i (parity_odd_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .parity_err_o (parity_err_o),
        .frame_err_o  (frame_err_o),
        .busy_o       (busy_o)
    );

    // Free-running system clock
    initial forever #5 clk_i = ~clk_i;

    // One-cycle tick every TICK_DIV clocks
    // Changed on the falling edge, so the DUT sees it stable
    initial forever begin
        @(negedge clk_i);
        div_cnt = (div_cnt + 1) % TICK_DIV;
        tick_i  = (div_cnt == 0);
    end

    // Monitor: record every cycle where valid_o is high
    initial forever begin
        @(negedge clk_i);
        if (valid_o === 1'b1) begin
            obs_q.push_back('{data_o, parity_err_o, frame_err_o});
        end
    end

    // Watchdog: every wait below is tick-based, this catches anything unforeseen
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Return on the rising edge of a clock cycle where tick_i is high
    task automatic waitTick();
        do @(posedge clk_i); while (tick_i !== 1'b1);
    endtask

    // Put one level on the line for n ticks, starting just after a tick edge
    task automatic driveBit(input logic v, input int n);
        #1 rx_i = v;
        repeat (n) waitTick();
    endtask

    // Send one complete frame: start, 8 data bits LSB first,
    // optional parity bit, then the stop bit.
    // toggle_odd flips parity_odd_i part way through the frame.
    task automatic applyStimulus(input logic [7:0] data, input bit par_en, input bit par_odd,
                                 input bit pbit, input bit stop, input bit toggle_odd);
        parity_en_i  = par_en;
        parity_odd_i = par_odd;
        driveBit(1'b0, OVERSAMPLE);
        for (int i = 0; i < DATA_BITS; i++) begin
            driveBit(data[i], OVERSAMPLE);
            if (toggle_odd && i == 3) begin
                parity_odd_i = ~parity_odd_i;
            end
        end
        if (par_en) begin
            driveBit(pbit, OVERSAMPLE);
        end
        driveBit(stop, OVERSAMPLE);
    endtask

    // Expect exactly one collected frame with the given contents
    task automatic checkFrame(input string name, input logic [7:0] exp_data,
                              input logic exp_perr, input logic exp_ferr);
        obs_t o;
        checkOutput({name, " valid count"}, obs_q.size(), 1);
        if (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            checkOutput({name, " data"}, o.data, exp_data);
            checkOutput({name, " parity_err"}, o.perr, exp_perr);
            checkOutput({name, " frame_err"}, o.ferr, exp_ferr);
        end
        obs_q.delete();
    endtask

    // Frame-level model: count the ones in data plus the parity bit
    function automatic logic modelPerr(input logic [7:0] data, input bit en, input bit odd, input bit pbit);
        int ones;
        if (!en) return 1'b0;
        ones = $countones(data) + int'(pbit);
        return ((ones % 2) == 1) != odd;
    endfunction

    initial begin
        logic [7:0] r_data;
        bit         r_en, r_odd, r_pbit, r_stop;

        vecs[0]  = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0};
        vecs[1]  = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[2]  = '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0};
        vecs[3]  = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0};
        vecs[4]  = '{8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0};
        vecs[5]  = '{8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 8'h12, 1'b0, 1'b0};
        vecs[6]  = '{8'h07, 1'b1, 1'b0, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
        vecs[7]  = '{8'hFE, 1'b1, 1'b1, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[8]  = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[9]  = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1};
        vecs[10] = '{8'h81, 1'b1, 1'b0, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1};
        vecs[11] = '{8'hC3, 1'b1, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b0};

        // Reset values
        rst_i = 1'b1;
        repeat (5) @(negedge clk_i);
        checkOutput("reset data_o", data_o, 0);
        checkOutput("reset valid_o", valid_o, 0);
        checkOutput("reset parity_err_o", parity_err_o, 0);
        checkOutput("reset frame_err_o", frame_err_o, 0);
        checkOutput("reset busy_o", busy_o, 0);
        rst_i = 1'b0;
        waitTick();
        driveBit(1'b1, 4);

        // Table-driven frames
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].data, vecs[i].par_en, vecs[i].par_odd, vecs[i].pbit, vecs[i].stop, 1'b0);
            driveBit(1'b1, 3);
            checkFrame($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_ferr);
            #1 checkOutput($sformatf("vec%0d busy after", i), busy_o, 0);
        end

        // Changing parity_odd_i mid-frame must not affect the result
        applyStimulus(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        driveBit(1'b1, 3);
        checkFrame("toggle odd ok", 8'h3C, 1'b0, 1'b0);
        applyStimulus(8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        driveBit(1'b1, 3);
        checkFrame("toggle odd err", 8'h3C, 1'b1, 1'b0);

        // Glitch: line low for 4 ticks only
        parity_en_i = 1'b0;
        driveBit(1'b0, 2);
        #1 checkOutput("glitch busy during", busy_o, 1);
        driveBit(1'b0, 2);
        driveBit(1'b1, 20);
        #1 checkOutput("glitch no valid", obs_q.size(), 0);
        checkOutput("glitch busy after", busy_o, 0);
        applyStimulus(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        driveBit(1'b1, 3);
        checkFrame("after glitch", 8'h12, 1'b0, 1'b0);

        // Break: stop bit low, then line held low for 100 ticks
        applyStimulus(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        driveBit(1'b0, 100);
        checkFrame("break", 8'hFF, 1'b0, 1'b1);
        #1 checkOutput("break busy held", busy_o, 1);
        driveBit(1'b1, 5);
        #1 checkOutput("break busy released", busy_o, 0);
        applyStimulus(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        driveBit(1'b1, 3);
        checkFrame("after break", 8'h81, 1'b0, 1'b0);

        // Reset pulse during data bit 3 of a 0xC3 frame
        parity_en_i = 1'b0;
        driveBit(1'b0, OVERSAMPLE);
        driveBit(1'b1, OVERSAMPLE);
        driveBit(1'b1, OVERSAMPLE);
        driveBit(1'b0, OVERSAMPLE);
        driveBit(1'b0, OVERSAMPLE / 2);
        #1 checkOutput("mid-frame busy", busy_o, 1);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        checkOutput("mid reset data_o", data_o, 0);
        checkOutput("mid reset valid_o", valid_o, 0);
        checkOutput("mid reset parity_err_o", parity_err_o, 0);
        checkOutput("mid reset frame_err_o", frame_err_o, 0);
        checkOutput("mid reset busy_o", busy_o, 0);
        rx_i  = 1'b1;
        rst_i = 1'b0;
        waitTick();
        driveBit(1'b1, 30);
        #1 checkOutput("aborted frame no valid", obs_q.size(), 0);
        applyStimulus(8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        driveBit(1'b1, 3);
        checkFrame("after reset", 8'h0F, 1'b0, 1'b0);

        // Random frames against the frame-level model
        for (int k = 0; k < 16; k++) begin
            r_data = 8'($urandom);
            r_en   = 1'($urandom_range(0, 1));
            r_odd  = 1'($urandom_range(0, 1));
            r_pbit = 1'($urandom_range(0, 1));
            r_stop = ($urandom_range(0, 5) != 0);
            applyStimulus(r_data, r_en, r_odd, r_pbit, r_stop, 1'b0);
            driveBit(1'b1, 3);
            checkFrame($sformatf("rand%0d", k), r_data, modelPerr(r_data, r_en, r_odd, r_pbit), !r_stop);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
